// File: rtl/my_div_pkg.sv
// Shared definitions for the signed restoring divider: FSM encodings, default width
// and the constants that identify the single signed-overflow case.
package my_div_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [DEF_WIDTH-1:0] MIN_INT = 32'h8000_0000;
    localparam logic [DEF_WIDTH-1:0] NEG_ONE = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes; purely combinational.
// The partial remainder stays below the divisor, so it always fits in WIDTH bits.
module div_step
    import my_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] r_sh;
    logic [WIDTH:0] diff;

    assign r_sh = {r, q[WIDTH-1]};
    // Subtract as add-of-complement; the extra top bit is the sign of the trial result.
    assign diff = r_sh + ~{1'b0, d} + {{WIDTH{1'b0}}, 1'b1};

    assign r_next = diff[WIDTH] ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    assign q_next = {q[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/my_div.sv
// Signed multicycle divider: truncating quotient/remainder, WIDTH+2 cycles (2 on divide-by-zero).
// Starts only from IDLE; ctrl_div while busy is dropped, results hold until the next operation.
module my_div
    import my_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state, state_nx;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rr, qq, dd;
    logic [WIDTH-1:0] r_next, q_next;
    logic             sign_q, sign_r, exc_pend;

    logic [WIDTH-1:0] a_abs, b_abs;
    logic             b_zero, ovf;

    assign a_abs  = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign b_abs  = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    assign b_zero = (data_operandB == '0);
    assign ovf    = data_operandA[WIDTH-1] & ~|data_operandA[WIDTH-2:0] & (&data_operandB);

    div_step #(.WIDTH(WIDTH)) u_step (
        .r      (rr),
        .q      (qq),
        .d      (dd),
        .r_next (r_next),
        .q_next (q_next)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (ctrl_div) state_nx = b_zero ? FIX : RUN;
            RUN:  if (count == LAST) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count          <= '0;
            rr             <= '0;
            qq             <= '0;
            dd             <= '0;
            sign_q         <= 1'b0;
            sign_r         <= 1'b0;
            exc_pend       <= 1'b0;
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
        end else begin
            case (state)
                IDLE: if (ctrl_div) begin
                    count    <= '0;
                    dd       <= b_abs;
                    sign_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                    sign_r   <= data_operandA[WIDTH-1];
                    exc_pend <= b_zero | ovf;
                    // On divide-by-zero, parking |A| in the remainder lets FIX restore A itself.
                    rr       <= b_zero ? a_abs : '0;
                    qq       <= b_zero ? '0 : a_abs;
                end
                RUN: begin
                    rr    <= r_next;
                    qq    <= q_next;
                    count <= count + 1'b1;
                end
                FIX: begin
                    data_result    <= sign_q ? -qq : qq;
                    data_remainder <= sign_r ? -rr : rr;
                    data_exception <= exc_pend;
                end
                default: ;
            endcase
        end
    end

    assign data_resultRDY = (state == DONE);
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_my_div.sv
// Directed vectors for my_div; expectations go into a scoreboard queue that a
// separate monitor drains whenever data_resultRDY is seen.
module tb_my_div;
    import my_div_pkg::*;

    logic        clock;
    logic        reset_n;
    logic        ctrl_div;
    logic [31:0] data_operandA, data_operandB;
    logic [31:0] data_result, data_remainder;
    logic        data_exception, data_resultRDY, busy;

    typedef struct {
        logic [31:0] res;
        logic [31:0] rem;
        logic        exc;
        int          lat;
        int          start;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    logic prev_rdy = 1'b0;

    my_div #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_div       (ctrl_div),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_remainder (data_remainder),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every completion pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (data_resultRDY) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_rdy: data_resultRDY high with nothing outstanding (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("result", data_result, e.res);
                check("remainder", data_remainder, e.rem);
                check("exception", {31'b0, data_exception}, {31'b0, e.exc});
                check("latency", 32'(cyc - e.start + 1), 32'(e.lat));
                check("rdy_width", {31'b0, prev_rdy}, 32'h0);
            end
        end
        prev_rdy = data_resultRDY;
    end

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic push,
                            input logic [31:0] res, input logic [31:0] rem, input logic exc,
                            input int lat);
        exp_t x;
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_div      = 1'b1;
        if (push) begin
            x.res = res; x.rem = rem; x.exc = exc; x.lat = lat; x.start = cyc + 1;
            sb.push_back(x);
        end
        @(negedge clock);
        ctrl_div = 1'b0;
        check("busy_after_start", {31'b0, busy}, 32'h1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || sb.size() != 0) && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (n >= 60) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: busy=%b outstanding=%0d after %0d cycles", busy, sb.size(), n);
            sb.delete();
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic [31:0] rem, input logic exc,
                          input int lat);
        start_op(a, b, 1'b1, res, rem, exc, lat);
        wait_idle();
    endtask

    initial begin
        reset_n       = 1'b0;
        ctrl_div      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(negedge clock);
        check("reset_result", data_result, 32'h0);
        check("reset_remainder", data_remainder, 32'h0);
        check("reset_exception", {31'b0, data_exception}, 32'h0);
        check("reset_rdy", {31'b0, data_resultRDY}, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        reset_n = 1'b1;
        @(negedge clock);

        run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
        run_op(-32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34);
        run_op(32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 1'b0, 34);
        run_op(-32'sd100, -32'sd7, 32'd14, 32'hFFFF_FFFE, 1'b0, 34);
        run_op(32'd5, 32'd0, 32'd0, 32'd5, 1'b1, 2);
        repeat (3) @(negedge clock);
        check("hold_result", data_result, 32'd0);
        check("hold_remainder", data_remainder, 32'd5);
        check("hold_exception", {31'b0, data_exception}, 32'h1);
        run_op(-32'sd7, 32'd0, 32'd0, 32'hFFFF_FFF9, 1'b1, 2);
        run_op(MIN_INT, NEG_ONE, 32'h8000_0000, 32'd0, 1'b1, 34);
        run_op(MIN_INT, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 34);
        run_op(32'd7, 32'd100, 32'd0, 32'd7, 1'b0, 34);

        // Second request arrives mid-operation and must be dropped.
        start_op(32'd1000, 32'd3, 1'b1, 32'd333, 32'd1, 1'b0, 34);
        repeat (3) @(negedge clock);
        data_operandA = 32'd9;
        data_operandB = 32'd3;
        ctrl_div      = 1'b1;
        @(negedge clock);
        ctrl_div = 1'b0;
        wait_idle();

        // Abort mid-operation with reset; no completion may follow.
        start_op(32'd1000, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0, 0);
        repeat (8) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("abort_result", data_result, 32'h0);
        check("abort_remainder", data_remainder, 32'h0);
        check("abort_exception", {31'b0, data_exception}, 32'h0);
        check("abort_busy", {31'b0, busy}, 32'h0);
        check("abort_rdy", {31'b0, data_resultRDY}, 32'h0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (40) @(negedge clock);
        run_op(32'd42, 32'd6, 32'd7, 32'd0, 1'b0, 34);

        repeat (3) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
